uart_tx_fifo: RTL and testbench

- 8N1 UART transmitter with a small input FIFO.
- Mirrors the board's UART receive path: ClockBaseTop status and echo bytes go back out on a PMOD JB pin to the host.
- Sits beside the clock-base core in the top-level IO wrapper.
- Accepts bytes through a valid/ready handshake and serialises them LSB-first at a fixed baud rate.

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter behind a FIFO_DEPTH-byte valid/ready queue; the line is one flop behind the FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        CLK,
  input  logic                        reset_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FIFO_FULL = (PW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Assertion is immediate; release is delayed two edges so no flop sees a runt reset edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_out_q, tx_out_d;
  logic          busy_q, busy_d;
  logic          tx_ready_q, tx_ready_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          push, pop, bit_end;

  assign push = tx_valid && tx_ready_q;

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    bit_end = (baud_q == BAUD_LAST);
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          sh_d    = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames leave with no idle gap.
          if (count_q != '0) begin
            pop     = 1'b1;
            sh_d    = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    tx_ready_d = (count_d != FIFO_FULL);
    busy_d     = (state_q != S_IDLE) || (count_q != '0);
    tx_out_d   = 1'b1;
    case (state_q)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = sh_q[idx_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_out_d = ^sh_q;
`endif
      default:  tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      idx_q      <= 3'd0;
      sh_q       <= 8'h00;
      tx_out_q   <= 1'b1;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      tx_out_q   <= tx_out_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign tx_ready   = tx_ready_q;
  assign tx_out     = tx_out_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo: a queue-and-timestamp model predicts accepted bytes,
// frame start cycles and per-cycle ready/count/busy; a line monitor decodes frames and compares.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic                     CLK      = 1'b0;
  logic                     reset_n  = 1'b1;
  logic [7:0]               tx_data  = 8'h00;
  logic                     tx_valid = 1'b0;
  logic                     tx_ready, tx_out, busy;
  logic [$clog2(DEPTH):0]   fifo_count;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  int vectors = 0, miscompares = 0, cyc = 0, frames_rx = 0;
  bit model_en = 0, chk_en = 0, mon_en = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_b[$];
  int         exp_t[$];
  int         m_free_at = 0;
  bit         m_active = 0, exp_busy = 0, exp_rdy = 0, do_push, do_pop;
  int         exp_cnt = 0;

  task automatic check(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: FIFO is a queue; the serialiser can take a byte at any edge at or after the
  // previous take plus one frame; the line starts the start bit one edge after the take.
  initial forever begin
    @(posedge CLK);
    cyc++;
    if (model_en) begin
      exp_busy = m_active || (mq.size() != 0);
      do_push  = tx_valid && (mq.size() < DEPTH);
      do_pop   = (cyc >= m_free_at) && (mq.size() != 0);
      if (do_pop) begin
        exp_b.push_back(mq.pop_front());
        exp_t.push_back(cyc + 1);
        m_free_at = cyc + FRAME;
      end
      if (do_push) mq.push_back(tx_data);
      m_active = (cyc < m_free_at);
      exp_cnt  = mq.size();
      exp_rdy  = (exp_cnt != DEPTH);
    end
  end

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      check("tx_ready", tx_ready, exp_rdy);
      check("fifo_count", fifo_count, exp_cnt);
      check("busy", busy, exp_busy);
    end
  end

  int         mon_s, e_t;
  logic [7:0] mon_d, e_b;
  logic       mon_st, mon_sp, mon_par;
  bit         prev_line = 1'b1;

  initial forever begin
    @(negedge CLK);
    if (mon_en && prev_line && tx_out === 1'b0) begin
      mon_s   = cyc;
      mon_par = 1'b0;
      repeat (CPB / 2) @(negedge CLK);
      mon_st = tx_out;
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge CLK);
        mon_d[k] = tx_out;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(negedge CLK);
      mon_par = tx_out;
`endif
      repeat (CPB) @(negedge CLK);
      mon_sp = tx_out;
      frames_rx++;
      if (exp_b.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: got byte %02h at cycle %0d, no frame expected", mon_d, mon_s);
      end else begin
        e_b = exp_b.pop_front();
        e_t = exp_t.pop_front();
        check("frame_data", mon_d, e_b);
        check("start_cycle", mon_s, e_t);
        check("start_bit", mon_st, 0);
        check("stop_bit", mon_sp, 1);
`ifdef UART_TX_PARITY_EN
        check("parity_bit", mon_par, ^e_b);
`endif
      end
    end
    prev_line = tx_out;
  end

  task automatic drive(input bit v, input logic [7:0] d);
    tx_valid = v;
    tx_data  = d;
    @(negedge CLK);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(mq.size() == 0 && exp_b.size() == 0 && cyc >= m_free_at + 2) && n < 40 * FRAME) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_drained"}, mq.size() + exp_b.size(), 0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic release_reset();
    int n = 0;
    reset_n = 1'b1;
    while (tx_ready !== 1'b1 && n < 8) begin
      @(negedge CLK);
      n++;
    end
    check("ready_after_release", n, 3);
    mq.delete();
    exp_b.delete();
    exp_t.delete();
    m_free_at = 0;
    m_active  = 1'b0;
    model_en  = 1'b1;
    @(negedge CLK);
    chk_en = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int f0, n;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_tx_out", tx_out, 1);
    check("reset_tx_ready", tx_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_fifo_count", fifo_count, 0);
    release_reset();

    f0 = frames_rx;
    drive(1, 8'hA5);
    drive(0, 8'h00);
    wait_idle("single");
    check("single_frames", frames_rx - f0, 1);

    f0 = frames_rx;
    drive(1, 8'h00);
    drive(1, 8'hFF);
    drive(1, 8'h55);
    drive(0, 8'h00);
    wait_idle("b2b");
    check("b2b_frames", frames_rx - f0, 3);

    f0 = frames_rx;
    for (int i = 0; i < 20; i++) drive(1, 8'($urandom));
    drive(0, 8'h00);
    wait_idle("overflow");
    check("overflow_frames", frames_rx - f0, 17);

    f0 = frames_rx;
    drive(1, 8'hC3);
    drive(1, 8'h3C);
    drive(0, 8'h00);
    n = 0;
    while (cyc < m_free_at - 1 && n < 4 * FRAME) begin
      @(negedge CLK);
      n++;
    end
    drive(1, 8'h96);
    check("simul_count", fifo_count, 1);
    drive(0, 8'h00);
    wait_idle("simul");
    check("simul_frames", frames_rx - f0, 3);

    drive(1, 8'h07);
    drive(1, 8'h03);
    drive(0, 8'h00);
    wait_idle("parity");

    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) drive($urandom_range(0, 3) != 0, 8'($urandom));
      tx_valid = 1'b0;
      repeat ($urandom_range(0, 2 * FRAME)) @(negedge CLK);
    end
    wait_idle("random");

    mon_en = 1'b0;
    drive(1, 8'h00);
    drive(1, 8'h11);
    drive(1, 8'h22);
    drive(0, 8'h00);
    repeat (FRAME / 2) @(negedge CLK);
    #2;
    chk_en   = 1'b0;
    model_en = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("midframe_tx_out", tx_out, 1);
    check("midframe_fifo_count", fifo_count, 0);
    check("midframe_busy", busy, 0);
    check("midframe_tx_ready", tx_ready, 0);
    repeat (3) @(negedge CLK);
    release_reset();

    f0 = frames_rx;
    drive(1, 8'h5A);
    drive(0, 8'h00);
    wait_idle("post_reset");
    check("post_reset_frames", frames_rx - f0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #(90000 * 10);
    miscompares++;
    $display("FAIL watchdog: run did not complete within 90000 cycles");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
